// File: rtl/noc_link_fifo_if.sv
// Noc_flit_interface
// Flit link bundle between two router ports, or between a router port and an NI.
//   valid    : flit present on this link (driven by the sender)
//   flit     : flit payload, FLIT_WIDTH bits (driven by the sender)
//   ready    : the receiving side accepts the flit this cycle
//   vc_ready : per-VC readiness, returned from the receiver to the sender
// Modports:
//   receiver : consumes flits; drives ready and vc_ready
//   sender   : produces flits; drives valid and flit
interface Noc_flit_interface #(
   parameter int FLIT_WIDTH = 32,
   parameter int VC_NUM     = 4
);
   logic                  valid;
   logic [FLIT_WIDTH-1:0] flit;
   logic                  ready;
   logic [VC_NUM-1:0]     vc_ready;

   modport receiver (
      input  valid,
      input  flit,
      output ready,
      output vc_ready
   );

   modport sender (
      output valid,
      output flit,
      input  ready,
      input  vc_ready
   );
endinterface

// File: rtl/noc_link_fifo.sv
// noc_link_fifo
// Circular flit FIFO placed in front of the link pass-through stage. Flits are
// accepted on receiver_if, stored in order, and presented on sender_if. The
// downstream per-VC readiness is sent back upstream through one register stage,
// which cuts the long backward timing path.
//
// Ports:
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset (pointers, count, vc_ready)
//   receiver_if : upstream link (valid/flit in, ready/vc_ready out)
//   sender_if   : downstream link (valid/flit out, ready/vc_ready in)
//   occupancy   : number of flits currently stored
//
// Build option:
//   NOC_LINK_FIFO_BYPASS_EN : when defined, an empty FIFO forwards the incoming
//   flit combinationally (zero latency). The flit is written into storage only
//   if the downstream side is not ready. When undefined, the FIFO is purely
//   registered and has one cycle of latency.
module noc_link_fifo #(
   parameter int DEPTH      = 4,
   parameter int FLIT_WIDTH = 32,
   parameter int VC_NUM     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   Noc_flit_interface.receiver        receiver_if,
   Noc_flit_interface.sender          sender_if,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [FLIT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [VC_NUM-1:0]     vc_ready_q;

   logic                  in_ready;
   logic                  out_valid;
   logic [FLIT_WIDTH-1:0] out_flit;
   logic                  pass_thru;
   logic                  push;
   logic                  pop;
   logic                  wr_en;
   logic                  rd_en;

   // Upstream readiness depends only on the stored count, never on
   // sender_if.ready, so no combinational path runs backwards through the FIFO.
   always_comb begin
      in_ready  = (count != FULL_CNT);
      out_valid = (count != '0);
      out_flit  = mem[rd_ptr];
      pass_thru = 1'b0;
`ifdef NOC_LINK_FIFO_BYPASS_EN
      if (count == '0) begin
         out_valid = receiver_if.valid;
         out_flit  = receiver_if.flit;
         pass_thru = receiver_if.valid && sender_if.ready;
      end
`endif
      push  = receiver_if.valid && in_ready;
      pop   = out_valid && sender_if.ready;
      // A flit that passes straight through is neither stored nor read back.
      wr_en = push && !pass_thru;
      rd_en = pop && !pass_thru;
   end

   assign receiver_if.ready    = in_ready;
   assign receiver_if.vc_ready = vc_ready_q;
   assign sender_if.valid      = out_valid;
   assign sender_if.flit       = out_flit;
   assign occupancy            = count;

   // Control state; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         vc_ready_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         vc_ready_q <= sender_if.vc_ready;
      end
   end

   // Flit storage carries no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= receiver_if.flit;
   end

endmodule

// File: tb/tb_noc_link_fifo.sv
module tb_noc_link_fifo;

   localparam int DEPTH = 4;
   localparam int FW    = 32;
   localparam int VCN   = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   Noc_flit_interface #(.FLIT_WIDTH(FW), .VC_NUM(VCN)) up_if ();
   Noc_flit_interface #(.FLIT_WIDTH(FW), .VC_NUM(VCN)) dn_if ();

   noc_link_fifo #(.DEPTH(DEPTH), .FLIT_WIDTH(FW), .VC_NUM(VCN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .receiver_if (up_if),
      .sender_if   (dn_if),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard and reference model, evaluated on the falling edge.
   logic [FW-1:0]  sb_q[$];
   int             m_count = 0;
   logic [VCN-1:0] vc_exp = '0;

   always @(negedge clk) begin
      bit exp_valid, exp_ready, push, pop, byp;
      if (!rst_n) begin
         sb_q.delete();
         m_count = 0;
         vc_exp  = '0;
         check_eq("rst_ready", up_if.ready, 1'b1);
         check_eq("rst_occ", occupancy, 0);
         check_eq("rst_vc", up_if.vc_ready, '0);
      end else begin
         exp_ready = (m_count != DEPTH);
         exp_valid = (m_count != 0);
         byp = 1'b0;
`ifdef NOC_LINK_FIFO_BYPASS_EN
         if (m_count == 0) begin
            exp_valid = up_if.valid;
            byp = up_if.valid && dn_if.ready;
         end
`endif
         check_eq("occ", occupancy, m_count);
         check_eq("in_ready", up_if.ready, exp_ready);
         check_eq("out_valid", dn_if.valid, exp_valid);
         check_eq("vc_ready", up_if.vc_ready, vc_exp);
         push = up_if.valid && exp_ready;
         pop  = exp_valid && dn_if.ready;
         if (pop) begin
            if (byp) check_eq("bypass_flit", dn_if.flit, up_if.flit);
            else if (sb_q.size() == 0) check_eq("pop_empty_q", sb_q.size(), 1);
            else check_eq("pop_flit", dn_if.flit, sb_q.pop_front());
         end
         if (push && !byp) sb_q.push_back(up_if.flit);
         if ((push && !byp) && !(pop && !byp)) m_count++;
         else if (!(push && !byp) && (pop && !byp)) m_count--;
         vc_exp = dn_if.vc_ready;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one flit and hold it until accepted; returns just after the accepting edge.
   task automatic send(input logic [FW-1:0] v, input bit rnd);
      bit acc;
      acc = 1'b0;
      if (rnd) begin
         repeat ($urandom_range(0, 2)) begin
            up_if.valid = 1'b0;
            dn_if.ready = 1'($urandom_range(0, 1));
            step();
         end
      end
      up_if.valid = 1'b1;
      up_if.flit  = v;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = up_if.ready;
         step();
         if (rnd) dn_if.ready = 1'($urandom_range(0, 1));
      end
      if (!acc) check_eq("send_timeout", acc, 1'b1);
      up_if.valid = 1'b0;
   endtask

   task automatic drain();
      up_if.valid = 1'b0;
      dn_if.ready = 1'b1;
      for (int t = 0; t < 50 && occupancy != 0; t++) step();
      check_eq("drain_occ", occupancy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      up_if.valid    = 1'b0;
      up_if.flit     = '0;
      dn_if.ready    = 1'b0;
      dn_if.vc_ready = '0;

      // reset state
      #2;
      check_eq("reset_valid", dn_if.valid, 1'b0);
      check_eq("reset_ready", up_if.ready, 1'b1);
      check_eq("reset_vc", up_if.vc_ready, '0);
      check_eq("reset_occ", occupancy, 0);
      step();
      step();
      rst_n = 1'b1;

      // single flit latency
      up_if.valid = 1'b1;
      up_if.flit  = 32'hA5;
      dn_if.ready = 1'b1;
      @(negedge clk);
`ifdef NOC_LINK_FIFO_BYPASS_EN
      check_eq("t1_valid0", dn_if.valid, 1'b1);
      check_eq("t1_flit0", dn_if.flit, 32'hA5);
      check_eq("t1_occ0", occupancy, 0);
      step();
      up_if.valid = 1'b0;
      @(negedge clk);
      check_eq("t1_occ1", occupancy, 0);
      check_eq("t1_valid1", dn_if.valid, 1'b0);
`else
      check_eq("t1_valid0", dn_if.valid, 1'b0);
      step();
      up_if.valid = 1'b0;
      @(negedge clk);
      check_eq("t1_valid1", dn_if.valid, 1'b1);
      check_eq("t1_flit1", dn_if.flit, 32'hA5);
      check_eq("t1_occ1", occupancy, 1);
      step();
      @(negedge clk);
      check_eq("t1_occ2", occupancy, 0);
      check_eq("t1_valid2", dn_if.valid, 1'b0);
`endif
      step();

      // sustained throughput
      dn_if.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         up_if.valid = 1'b1;
         up_if.flit  = 32'h100 + i;
         @(negedge clk);
`ifdef NOC_LINK_FIFO_BYPASS_EN
         check_eq("burst_occ", occupancy, 0);
`else
         check_eq("burst_occ", occupancy, (i == 0) ? 0 : 1);
`endif
         check_eq("burst_ready", up_if.ready, 1'b1);
         step();
      end
      drain();

      // fill with downstream stalled
      dn_if.ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(FW'(i), 1'b0);
      up_if.valid = 1'b1;
      up_if.flit  = 32'd5;
      @(negedge clk);
      check_eq("full_ready", up_if.ready, 1'b0);
      check_eq("full_occ", occupancy, 4);
      step();
      @(negedge clk);
      check_eq("full_hold_ready", up_if.ready, 1'b0);
      step();

      // pop while full: push blocked this cycle, ready returns next cycle
      dn_if.ready = 1'b1;
      @(negedge clk);
      check_eq("fullpop_ready", up_if.ready, 1'b0);
      check_eq("fullpop_occ", occupancy, 4);
      step();
      @(negedge clk);
      check_eq("fullpop_ready_next", up_if.ready, 1'b1);
      check_eq("fullpop_occ_next", occupancy, 3);
      step();
      send(32'd6, 1'b0);
      drain();

      // random valid/ready traffic
      for (int i = 0; i < 1000; i++) send(32'h1000_0000 + FW'(i), 1'b1);
      drain();

      // vc_ready register stage
      dn_if.vc_ready = 4'b0001;
      step();
      dn_if.vc_ready = 4'b0110;
      @(negedge clk);
      check_eq("vc_step0", up_if.vc_ready, 4'b0001);
      step();
      @(negedge clk);
      check_eq("vc_step1", up_if.vc_ready, 4'b0110);
      step();

      // asynchronous reset with stored flits
      dn_if.ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h300 + FW'(i), 1'b0);
      @(negedge clk);
      check_eq("pre_rst_occ", occupancy, 3);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_valid", dn_if.valid, 1'b0);
      check_eq("async_occ", occupancy, 0);
      check_eq("async_vc", up_if.vc_ready, '0);
      check_eq("async_ready", up_if.ready, 1'b1);
      step();
      rst_n = 1'b1;
      dn_if.ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("post_rst_no_stale", dn_if.valid, 1'b0);
         step();
      end

      // first push right after reset release
      send(32'h5A, 1'b0);
      drain();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
